mw_adder_seq: RTL

MW_ADDER_SEQ -- requirements
Module: mw_adder_seq

---
 rtl/mw_adder_pkg.sv | 17 +
 rtl/ks_adder.sv | 41 ++++
 rtl/mw_adder_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mw_adder_pkg.sv
// Shared definitions for the multi-word sequential adder: default widths and FSM state type.
package mw_adder_pkg;

  localparam int DEFAULT_SIZE  = 8;
  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CHAIN = 1'b1
  } state_t;

  // A word marked last closes the operation; anything else leaves us inside a chain.
  function automatic state_t next_state(input logic last);
    return last ? ST_IDLE : ST_CHAIN;
  endfunction

endpackage

// File: rtl/ks_adder.sv
// Kogge-Stone parallel-prefix adder of one SIZE-bit slice with carry-in and carry-out.
module ks_adder #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  output logic [SIZE-1:0] sum,
  output logic            cout
);

  localparam int LEVELS = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [SIZE-1:0] w_g [0:LEVELS];
  logic [SIZE-1:0] w_p [0:LEVELS];

  // Prefix tree: the carry-in is folded into bit 0's generate so every group generate is a true carry.
  always_comb begin
    w_g[0]    = a & b;
    w_g[0][0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
    w_p[0]    = a ^ b;
    for (int k = 0; k < LEVELS; k++) begin
      w_g[k+1] = w_g[k];
      w_p[k+1] = w_p[k];
      for (int i = (1 << k); i < SIZE; i++) begin
        w_g[k+1][i] = w_g[k][i] | (w_p[k][i] & w_g[k][i-(1<<k)]);
        w_p[k+1][i] = w_p[k][i] & w_p[k][i-(1<<k)];
      end
    end
  end

  // Sum bit i is the raw propagate XOR the carry out of bits [i-1:0].
  always_comb begin
    sum[0] = w_p[0][0] ^ cin;
    for (int i = 1; i < SIZE; i++) begin
      sum[i] = w_p[0][i] ^ w_g[LEVELS][i-1];
    end
    cout = w_g[LEVELS][SIZE-1];
  end

endmodule

// File: rtl/mw_adder_seq.sv
// Multi-word sequential adder: adds operands one SIZE-bit word per accepted beat,
// least-significant word first, chaining the carry between words, with a single
// output register, sticky sequence-error flag and completed-operation counter.
// Optional subtraction (A-B) is enabled by defining MW_ADDER_SUB_EN, which adds the 'sub' port.
module mw_adder_seq
  import mw_adder_pkg::*;
#(
  parameter int SIZE  = DEFAULT_SIZE,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  in_a,
  input  logic [SIZE-1:0]  in_b,
  input  logic             in_first,
  input  logic             in_last,
`ifdef MW_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_sum,
  output logic             out_last,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             seq_err,
  output logic [CNT_W-1:0] op_count
);

  state_t           r_state;
  logic             r_carry;
  logic             r_out_valid;
  logic [SIZE-1:0]  r_out_sum;
  logic             r_out_last;
  logic             r_out_carry;
  logic             r_out_ovf;
  logic             r_seq_err;
  logic [CNT_W-1:0] r_op_count;

  logic             w_accept;
  logic             w_is_first;
  logic             w_sub_eff;
  logic             w_cin;
  logic             w_seq_viol;
  logic             w_ovf;
  logic [SIZE-1:0]  w_b_eff;
  logic [SIZE-1:0]  w_ks_sum;
  logic             w_ks_cout;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // A stray continuation word in IDLE is handled as the start of a new operation.
  assign w_is_first = in_first || (r_state == ST_IDLE);
  assign w_seq_viol = ((r_state == ST_IDLE) && !in_first) || ((r_state == ST_CHAIN) && in_first);

`ifdef MW_ADDER_SUB_EN
  logic r_sub;

  // The operation's add/subtract mode is captured on its first word and reused for the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub <= 1'b0;
    end else if (w_accept && w_is_first) begin
      r_sub <= sub;
    end
  end

  assign w_sub_eff = w_is_first ? sub : r_sub;
`else
  assign w_sub_eff = 1'b0;
`endif

  // Subtraction is A + ~B + 1, so the first word's carry-in equals the mode bit.
  assign w_cin   = w_is_first ? w_sub_eff : r_carry;
  assign w_b_eff = in_b ^ {SIZE{w_sub_eff}};
  assign w_ovf   = in_last && (in_a[SIZE-1] == w_b_eff[SIZE-1]) && (w_ks_sum[SIZE-1] != in_a[SIZE-1]);

  ks_adder #(
    .SIZE (SIZE)
  ) u_ks_adder (
    .a    (in_a),
    .b    (w_b_eff),
    .cin  (w_cin),
    .sum  (w_ks_sum),
    .cout (w_ks_cout)
  );

  // FSM and inter-word carry advance only on accepted words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_state <= next_state(in_last);
      r_carry <= w_ks_cout;
    end
  end

  // Output register: loads on accept, drains on consumer take, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_last  <= 1'b0;
      r_out_carry <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_ks_sum;
      r_out_last  <= in_last;
      r_out_carry <= w_ks_cout;
      r_out_ovf   <= w_ovf;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky protocol-error flag and wrap-around completed-operation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_err  <= 1'b0;
      r_op_count <= '0;
    end else if (w_accept) begin
      if (w_seq_viol) begin
        r_seq_err <= 1'b1;
      end
      if (in_last) begin
        r_op_count <= r_op_count + CNT_W'(1);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_last  = r_out_last;
  assign out_carry = r_out_carry;
  assign out_ovf   = r_out_ovf;
  assign seq_err   = r_seq_err;
  assign op_count  = r_op_count;

endmodule
